// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_if
// Brief    : Serial input, word handshake and status bundle for serial_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
) ();
    logic              bit_in;
    logic              bit_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    // master = receiver side, slave = line driver / word consumer side
    modport master (
        input  bit_in, bit_en, data_ready,
        output data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        output bit_in, bit_en, data_ready,
        input  data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Brief    : Strobed serial frame receiver (start, data, optional parity, stop)
//            with a one-entry valid/ready output register and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 0,
    parameter int MSB_FIRST  = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_frame_rx_if.master  rx
);

    localparam int   c_CNT_W = $clog2(DATA_W + 1);
    localparam logic c_ODD   = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_par_bad;
    logic                r_par_err;
    logic                r_frm_err;
    logic                r_ovr;
    logic                w_last_bit;

    always_comb begin
        w_shifted = r_shift;
        if (MSB_FIRST != 0) begin
            w_shifted = {r_shift[DATA_W-2:0], rx.bit_in};
        end else begin
            w_shifted = {rx.bit_in, r_shift[DATA_W-1:1]};
        end
    end

    assign w_last_bit = (r_cnt == c_CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (rx.bit_en) begin
            case (r_state)
                IDLE:    if (!rx.bit_in) w_next = DATA;
                DATA:    if (w_last_bit) w_next = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  w_next = STOP;
                STOP:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr     <= 1'b0;
            if (r_valid && rx.data_ready) begin
                r_valid <= 1'b0;
            end
            if (rx.bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (!rx.bit_in) begin
                            r_cnt     <= '0;
                            r_par_bad <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift <= w_shifted;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    PARITY: begin
                        r_par_bad <= (^r_shift) ^ rx.bit_in ^ c_ODD;
                    end
                    STOP: begin
                        // Framing beats parity; a good word overwrites only a free or draining register
                        if (!rx.bit_in) begin
                            r_frm_err <= 1'b1;
                        end else if (r_par_bad) begin
                            r_par_err <= 1'b1;
                        end else if (!r_valid || rx.data_ready) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.data_out   = r_data;
    assign rx.data_valid = r_valid;
    assign rx.parity_err = r_par_err;
    assign rx.frame_err  = r_frm_err;
    assign rx.overrun    = r_ovr;
    assign rx.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Brief    : Directed self-checking bench for serial_frame_rx (8 bits, MSB first, even parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   pulse_cnt;
    int   pulse_snap;

    serial_frame_rx_if #(.DATA_W(8)) rx_if ();

    serial_frame_rx #(
        .DATA_W     (8),
        .PARITY_EN  (1),
        .ODD_PARITY (0),
        .MSB_FIRST  (1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_if.parity_err || rx_if.frame_err || rx_if.overrun) pulse_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        rx_if.bit_in = b;
        rx_if.bit_en = 1'b1;
        @(negedge clk);
        rx_if.bit_en = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] d, input logic p);
        strobe(1'b0);
        gap();
        for (int i = 7; i >= 0; i--) begin
            strobe(d[i]);
            gap();
        end
        strobe(p);
        gap();
    endtask

    // Returns on the first negedge after the stop-bit sample edge
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_body(d, p);
        strobe(s);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pulse_cnt = 0;
        reset = 1'b1;
        rx_if.bit_in     = 1'b1;
        rx_if.bit_en     = 1'b0;
        rx_if.data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_data_out", rx_if.data_out, 32'h00);
        check_val("rst_valid", rx_if.data_valid, 0);
        check_val("rst_busy", rx_if.busy, 0);
        check_val("rst_pulses", {rx_if.parity_err, rx_if.frame_err, rx_if.overrun}, 0);
        reset = 1'b0;

        pulse_snap = pulse_cnt;
        for (int i = 0; i < 50; i++) begin
            strobe(1'b1);
            gap();
        end
        check_val("idle_busy", rx_if.busy, 0);
        check_val("idle_valid", rx_if.data_valid, 0);
        check_val("idle_pulses", pulse_cnt - pulse_snap, 0);

        send_frame(8'hA5, 1'b0, 1'b1);
        check_val("good_data", rx_if.data_out, 32'hA5);
        check_val("good_valid", rx_if.data_valid, 1);
        check_val("good_perr", rx_if.parity_err, 0);
        check_val("good_ferr", rx_if.frame_err, 0);
        @(negedge clk);
        check_val("good_valid_clr", rx_if.data_valid, 0);
        check_val("good_data_hold", rx_if.data_out, 32'hA5);
        gap();

        send_frame(8'hA5, 1'b1, 1'b1);
        check_val("perr_pulse", rx_if.parity_err, 1);
        check_val("perr_ferr", rx_if.frame_err, 0);
        check_val("perr_valid", rx_if.data_valid, 0);
        check_val("perr_data", rx_if.data_out, 32'hA5);
        @(negedge clk);
        check_val("perr_one_cycle", rx_if.parity_err, 0);
        gap();
        send_frame(8'h3C, 1'b0, 1'b1);
        check_val("after_perr_data", rx_if.data_out, 32'h3C);
        check_val("after_perr_valid", rx_if.data_valid, 1);
        gap();

        send_frame(8'h5A, 1'b0, 1'b0);
        check_val("ferr_pulse", rx_if.frame_err, 1);
        check_val("ferr_perr", rx_if.parity_err, 0);
        check_val("ferr_valid", rx_if.data_valid, 0);
        check_val("ferr_data", rx_if.data_out, 32'h3C);
        @(negedge clk);
        check_val("ferr_one_cycle", rx_if.frame_err, 0);
        gap();
        send_frame(8'h5A, 1'b1, 1'b0);
        check_val("prio_ferr", rx_if.frame_err, 1);
        check_val("prio_perr", rx_if.parity_err, 0);
        gap();

        send_frame(8'h07, 1'b1, 1'b1);
        check_val("odd_ones_data", rx_if.data_out, 32'h07);
        check_val("odd_ones_valid", rx_if.data_valid, 1);
        gap();

        rx_if.data_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_val("ovr_first_data", rx_if.data_out, 32'h3C);
        check_val("ovr_first_valid", rx_if.data_valid, 1);
        gap();
        send_frame(8'h81, 1'b0, 1'b1);
        check_val("ovr_pulse", rx_if.overrun, 1);
        check_val("ovr_data_kept", rx_if.data_out, 32'h3C);
        check_val("ovr_valid_kept", rx_if.data_valid, 1);
        @(negedge clk);
        check_val("ovr_one_cycle", rx_if.overrun, 0);
        check_val("ovr_valid_still", rx_if.data_valid, 1);
        rx_if.data_ready = 1'b1;
        @(negedge clk);
        check_val("ovr_accept_valid", rx_if.data_valid, 0);
        check_val("ovr_accept_data", rx_if.data_out, 32'h3C);
        rx_if.data_ready = 1'b0;
        gap();

        send_frame(8'h07, 1'b1, 1'b1);
        check_val("simul_first_valid", rx_if.data_valid, 1);
        gap();
        send_body(8'h81, 1'b0);
        @(negedge clk);
        rx_if.bit_in     = 1'b1;
        rx_if.bit_en     = 1'b1;
        rx_if.data_ready = 1'b1;
        @(negedge clk);
        rx_if.bit_en     = 1'b0;
        rx_if.data_ready = 1'b0;
        check_val("simul_data", rx_if.data_out, 32'h81);
        check_val("simul_valid", rx_if.data_valid, 1);
        check_val("simul_no_ovr", rx_if.overrun, 0);
        rx_if.data_ready = 1'b1;
        @(negedge clk);
        check_val("simul_accept", rx_if.data_valid, 0);
        gap();

        strobe(1'b0);
        gap();
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            gap();
        end
        check_val("mid_busy", rx_if.busy, 1);
        pulse_snap = pulse_cnt;
        @(negedge clk);
        reset        = 1'b1;
        rx_if.bit_en = 1'b1;
        rx_if.bit_in = 1'b0;
        @(negedge clk);
        reset        = 1'b0;
        rx_if.bit_en = 1'b0;
        rx_if.bit_in = 1'b1;
        check_val("mid_rst_busy", rx_if.busy, 0);
        gap();
        check_val("mid_rst_pulses", pulse_cnt - pulse_snap, 0);
        send_frame(8'h0F, 1'b0, 1'b1);
        check_val("post_rst_data", rx_if.data_out, 32'h0F);
        check_val("post_rst_valid", rx_if.data_valid, 1);
        gap();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
